// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
package rr_req_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Requester/consumer bundle around the arbiter: request and release lines in, grant out.
interface rr_req_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDX_W = rr_req_arbiter_pkg::idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_valid, gnt_idx, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, gnt_idx, timeout
  );
endinterface

// File: rtl/rr_req_arbiter_priority_enc.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping modulo N_REQ.
module rr_priority_enc #(
  parameter int N_REQ = 4,
  parameter int IDX_W = rr_req_arbiter_pkg::idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] pick
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any  = |req;
    pick = ptr;
    cand = '0;
    // Scan from the farthest offset down so the closest hit to ptr is written last.
    // N_REQ is a power of two, so the IDX_W-bit add wraps exactly modulo N_REQ.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: registered one-hot grant held until release, done or hold timeout.
module rr_req_arbiter
  import rr_req_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  rr_req_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int HC_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             to_q, to_d;

  logic             any;
  logic [IDX_W-1:0] pick;
  logic             rel;
  logic             tmo;

  rr_priority_enc #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_enc (
    .req  (bus.req),
    .ptr  (ptr_q),
    .any  (any),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    rel     = !bus.req[idx_q] || bus.done[idx_q];
    tmo     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    case (state_q)
      ARB_IDLE: begin
        if (any) begin
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          idx_d       = pick;
          hold_d      = '0;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (rel || tmo) begin
          gnt_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          to_d    = tmo && !rel;
          state_d = ARB_GAP;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      ARB_GAP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_rr_req_arbiter;

  localparam int N  = 4;
  localparam int MH = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_req_arbiter_if #(.N_REQ(N)) bus ();

  rr_req_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the resource, whether we are in the dead cycle, rotation start.
  int owner, last_idx, next_first, held;
  bit in_gap, m_to;

  task automatic model_reset();
    owner = -1; last_idx = 0; next_first = 0; held = 0; in_gap = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    bit released, expired;
    m_to = 0;
    if (in_gap) begin
      in_gap = 0;
    end else if (owner >= 0) begin
      released = (r[owner] == 1'b0) || (d[owner] == 1'b1);
      expired  = (MH != 0) && (held == MH - 1);
      if (released || expired) begin
        m_to       = expired && !released;
        next_first = (owner + 1) % N;
        owner      = -1;
        in_gap     = 1;
      end else if (held < MH) begin
        held++;
      end
    end else if (r != '0) begin
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && r[(next_first + k) % N]) owner = (next_first + k) % N;
      end
      last_idx = owner;
      held     = 0;
    end
  endtask

  function automatic logic [N+3:0] m_exp();
    logic [N-1:0] g;
    g = '0;
    if (owner >= 0) g[owner] = 1'b1;
    return {g, (owner >= 0), 2'(last_idx), m_to};
  endfunction

  task automatic tick();
    logic [N-1:0] r, d;
    logic rs;
    r = bus.req; d = bus.done; rs = rst;
    @(posedge clk);
    if (rs) model_reset(); else model_step(r, d);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bus.req = '0; bus.done = '0;
    model_reset();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 4'b1111; bus.done = '0;
    model_reset();
    tick(); tick();
    n_cmp++;
    if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_state: got gnt=%b vld=%b idx=%0d to=%b, want all zero",
               bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0 || bus.gnt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_grant: got gnt=%b idx=%0d, want 0001 idx 0", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_single();
    apply_reset();
    bus.req = 4'b0100;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b idx=%0d, want 0100 idx 2", bus.gnt, bus.gnt_idx);
    end
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    n_cmp++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done_release: got gnt=%b to=%b, want 0000 to 0", bus.gnt, bus.timeout);
    end
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_gap: got gnt=%b, want 0000", bus.gnt);
    end
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0100 || bus.gnt_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL single_regrant: got gnt=%b idx=%0d, want 0100 idx 2", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    bit prev_vld;
    apply_reset();
    bus.req = 4'b1111;
    prev_vld = 0;
    for (int c = 0; c < 60 && seq.size() < 5; c++) begin
      tick();
      n_cmp++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout} !== m_exp()) begin
        n_bad++;
        $display("FAIL rr_model cyc %0d: got %b, want %b", c,
                 {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout}, m_exp());
      end
      if (bus.gnt_valid && !prev_vld) seq.push_back(int'(bus.gnt_idx));
      prev_vld = bus.gnt_valid;
      bus.done = bus.gnt;
    end
    bus.done = '0;
    n_cmp++;
    if (seq.size() != 5) begin
      n_bad++;
      $display("FAIL rr_grant_count: got %0d grants, want 5 within budget", seq.size());
    end
    for (int k = 0; k < seq.size(); k++) begin
      n_cmp++;
      if (seq[k] != k % N) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got idx %0d, want %0d", k, seq[k], k % N);
      end
    end
  endtask

  task automatic test_timeout();
    int held_cycles;
    apply_reset();
    bus.req = 4'b0010;
    tick();
    held_cycles = 0;
    while (bus.gnt === 4'b0010 && held_cycles < 40) begin
      held_cycles++;
      tick();
    end
    n_cmp++;
    if (held_cycles != MH) begin
      n_bad++;
      $display("FAIL timeout_hold_len: got %0d cycles, want %0d", held_cycles, MH);
    end
    n_cmp++;
    if (bus.timeout !== 1'b1 || bus.gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL timeout_pulse: got to=%b gnt=%b, want to 1 gnt 0000", bus.timeout, bus.gnt);
    end
    tick();
    n_cmp++;
    if (bus.timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_one_cycle: got to=%b, want 0", bus.timeout);
    end
    for (int c = 0; c < 5 && bus.gnt !== 4'b0010; c++) tick();
    for (int c = 0; c < MH - 1; c++) tick();
    bus.done = 4'b0010;
    tick();
    bus.done = '0;
    n_cmp++;
    if (bus.timeout !== 1'b0 || bus.gnt !== 4'b0000) begin
      n_bad++;
      $display("FAIL timeout_done_at_limit: got to=%b gnt=%b, want to 0 gnt 0000", bus.timeout, bus.gnt);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bus.req = 4'b0100;
    tick();
    bus.done = 4'b0100; bus.req = 4'b0011;
    tick();
    bus.done = '0;
    tick(); tick();
    n_cmp++;
    if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL wrap_to_zero: got gnt=%b idx=%0d, want 0001 idx 0", bus.gnt, bus.gnt_idx);
    end
    bus.done = 4'b0001; bus.req = 4'b1001;
    tick();
    bus.done = '0;
    tick(); tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      n_bad++;
      $display("FAIL wrap_skip_to_three: got gnt=%b idx=%0d, want 1000 idx 3", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.req = 4'b1000;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000) begin
      n_bad++;
      $display("FAIL async_pre_grant: got gnt=%b, want 1000", bus.gnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL async_drop: got gnt=%b vld=%b idx=%0d, want 0000 0 0",
               bus.gnt, bus.gnt_valid, bus.gnt_idx);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
      n_bad++;
      $display("FAIL async_regrant: got gnt=%b idx=%0d, want 1000 idx 3", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      n_cmp++;
      if ({bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout} !== m_exp()) begin
        n_bad++;
        $display("FAIL random_model cyc %0d: got %b, want %b", c,
                 {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout}, m_exp());
      end
      n_cmp++;
      if (!$onehot0(bus.gnt) || bus.gnt_valid !== (|bus.gnt)) begin
        n_bad++;
        $display("FAIL random_onehot cyc %0d: got gnt=%b vld=%b, want onehot0 and vld==|gnt",
                 c, bus.gnt, bus.gnt_valid);
      end
    end
    bus.req = '0; bus.done = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.done = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
